// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage controller for a slow handshaked memory (IDLE/BUSY/DONE)
// Optional one-entry read buffer: define MEM_ACCESS_CTRL_RDBUF_EN.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module mem_access_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 MEM_R_EN,
  input  logic                 MEM_W_EN,
  input  logic [`WORD_LEN-1:0] ALU_res,
  input  logic [`WORD_LEN-1:0] ST_value,
  output logic                 freeze,
  output logic [`WORD_LEN-1:0] dataMem_out,
  output logic                 err,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [`WORD_LEN-1:0] mem_addr,
  output logic [`WORD_LEN-1:0] mem_wdata,
  input  logic [`WORD_LEN-1:0] mem_rdata,
  input  logic                 mem_ack
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  // BUSY lasts at most TIMEOUT cycles; the last one aborts when the counter sits here
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]           state;
  logic [7:0]           wait_cnt;
  logic [`WORD_LEN-1:0] rd_data;
  logic                 access;
  logic                 hit;

  assign access = MEM_R_EN | MEM_W_EN;

`ifdef MEM_ACCESS_CTRL_RDBUF_EN
  logic                 buf_valid;
  logic [`WORD_LEN-1:0] buf_tag;
  logic [`WORD_LEN-1:0] buf_data;

  assign hit = (state == IDLE) & MEM_R_EN & ~MEM_W_EN & buf_valid & (buf_tag == ALU_res);
  assign dataMem_out = hit ? buf_data : rd_data;

  // Only ack-completed accesses touch the buffer, so aborted reads never fill it
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
    end else if (state == BUSY && mem_ack) begin
      if (!mem_we) begin
        buf_valid <= 1'b1;
        buf_tag   <= mem_addr;
        buf_data  <= mem_rdata;
      end else if (buf_valid && buf_tag == mem_addr) begin
        buf_data  <= mem_wdata;
      end
    end
  end
`else
  assign hit = 1'b0;
  assign dataMem_out = rd_data;
`endif

  assign freeze = access & (state != DONE) & ~hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_data   <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (access && !hit) begin
            mem_req   <= 1'b1;
            mem_we    <= MEM_W_EN;
            mem_addr  <= ALU_res;
            mem_wdata <= ST_value;
            wait_cnt  <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!mem_we) rd_data <= mem_rdata;
            state   <= DONE;
          end else if (wait_cnt == CNT_LAST) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            err     <= 1'b1;
            if (!mem_we) rd_data <= '0;
            state   <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl
`timescale 1ns/1ps
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_R_EN, MEM_W_EN;
  logic [31:0] ALU_res, ST_value;
  logic        freeze;
  logic [31:0] dataMem_out;
  logic        err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;

  int checks = 0;
  int failures = 0;
  int n;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .ALU_res(ALU_res), .ST_value(ST_value), .freeze(freeze),
    .dataMem_out(dataMem_out), .err(err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // all drive/sample happens at the falling edge, away from the active edge
  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; MEM_R_EN = 0; MEM_W_EN = 0; ALU_res = 0; ST_value = 0;
    mem_rdata = 0; mem_ack = 0;
    tick(); tick();
    check("rst_req", {31'd0, mem_req}, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_dout", dataMem_out, 0);
    check("rst_err", {31'd0, err}, 0);
    check("rst_freeze", {31'd0, freeze}, 0);
    rst = 1'b0;

    // read 0x40, ack in 3rd BUSY cycle
    tick();
    MEM_R_EN = 1; ALU_res = 32'h40; #1;
    n = 0;
    if (freeze) n++;
    tick();
    check("rd_req", {31'd0, mem_req}, 1);
    check("rd_addr", mem_addr, 32'h40);
    check("rd_we", {31'd0, mem_we}, 0);
    if (freeze) n++;
    tick(); if (freeze) n++;
    tick(); if (freeze) n++;
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 0; mem_rdata = 0;
    check("rd_freeze_cycles", n, 4);
    check("rd_done_freeze", {31'd0, freeze}, 0);
    check("rd_dout", dataMem_out, 32'hDEADBEEF);
    check("rd_err", {31'd0, err}, 0);
    check("rd_done_req", {31'd0, mem_req}, 0);
    MEM_R_EN = 0;

    // write 0x44 = 0x12345678, ack after one BUSY cycle
    tick();
    MEM_W_EN = 1; ALU_res = 32'h44; ST_value = 32'h12345678;
    tick();
    check("wr_we", {31'd0, mem_we}, 1);
    check("wr_wdata", mem_wdata, 32'h12345678);
    mem_ack = 1;
    tick();
    mem_ack = 0;
    check("wr_we_drop", {31'd0, mem_we}, 0);
    check("wr_req_drop", {31'd0, mem_req}, 0);
    check("wr_dout_kept", dataMem_out, 32'hDEADBEEF);
    MEM_W_EN = 0;

    // ack while idle must be ignored
    tick();
    mem_ack = 1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_ack = 0;
    check("idle_ack_req", {31'd0, mem_req}, 0);
    check("idle_ack_dout", dataMem_out, 32'hDEADBEEF);

    // read timeout with TIMEOUT=15
    MEM_R_EN = 1; ALU_res = 32'h50;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mem_req) n++;
      else break;
    end
    check("to_busy_cycles", n, 15);
    check("to_err", {31'd0, err}, 1);
    check("to_dout", dataMem_out, 0);
    check("to_freeze", {31'd0, freeze}, 0);
    MEM_R_EN = 0;

    // read+write together: write only, dataMem_out unchanged, err sticky
    tick();
    MEM_R_EN = 1; MEM_W_EN = 1; ALU_res = 32'h60; ST_value = 32'hA5A5A5A5;
    tick();
    check("rw_we", {31'd0, mem_we}, 1);
    mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
    tick();
    mem_ack = 0;
    check("rw_dout", dataMem_out, 0);
    check("rw_err_sticky", {31'd0, err}, 1);
    MEM_R_EN = 0; MEM_W_EN = 0;

    // reset during BUSY with read held, then reissue
    tick();
    MEM_R_EN = 1; ALU_res = 32'h70;
    tick();
    check("rb_busy_req", {31'd0, mem_req}, 1);
    rst = 1;
    tick();
    check("rb_req", {31'd0, mem_req}, 0);
    check("rb_addr", mem_addr, 0);
    check("rb_err", {31'd0, err}, 0);
    check("rb_freeze", {31'd0, freeze}, 1);
    rst = 0;
    tick();
    check("rb_reissue", {31'd0, mem_req}, 1);
    check("rb_reissue_addr", mem_addr, 32'h70);

    // back-to-back: complete, DONE, IDLE, then issue 0x74
    mem_ack = 1; mem_rdata = 32'h11112222;
    tick();
    mem_ack = 0;
    ALU_res = 32'h74;
    check("bb_done_freeze", {31'd0, freeze}, 0);
    check("bb_dout", dataMem_out, 32'h11112222);
    tick();
    check("bb_idle_req", {31'd0, mem_req}, 0);
    check("bb_idle_freeze", {31'd0, freeze}, 1);
    tick();
    check("bb_req2", {31'd0, mem_req}, 1);
    check("bb_addr2", mem_addr, 32'h74);
    mem_ack = 1; mem_rdata = 32'h33334444;
    tick();
    mem_ack = 0; MEM_R_EN = 0;
    tick();

`ifdef MEM_ACCESS_CTRL_RDBUF_EN
    MEM_R_EN = 1; ALU_res = 32'h80;
    tick();
    mem_ack = 1; mem_rdata = 32'h55;
    tick();
    mem_ack = 0; MEM_R_EN = 0;
    check("buf_fill", dataMem_out, 32'h55);
    tick();
    MEM_W_EN = 1; ST_value = 32'h66;
    tick();
    mem_ack = 1;
    tick();
    mem_ack = 0; MEM_W_EN = 0;
    tick();
    MEM_R_EN = 1; #1;
    check("buf_hit_freeze", {31'd0, freeze}, 0);
    check("buf_hit_dout", dataMem_out, 32'h66);
    tick();
    check("buf_hit_noreq", {31'd0, mem_req}, 0);
    MEM_R_EN = 0;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15: max cycles BUSY waits for mem_ack before aborting; legal range 1..255.
REQ-002 Data and address widths SHALL be `WORD_LEN (32); wait counter SHALL be 8 bits.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 MEM_R_EN  in  1  pipeline load request, held stable while freeze=1.
REQ-006 MEM_W_EN  in  1  pipeline store request, held stable while freeze=1.
REQ-007 ALU_res  in  `WORD_LEN  access address.
REQ-008 ST_value  in  `WORD_LEN  store data.
REQ-009 freeze  out  1  combinational stall to all pipeline registers.
REQ-010 dataMem_out  out  `WORD_LEN  load result to MEM/WB register.
REQ-011 err  out  1  sticky timeout flag.
REQ-012 mem_req, mem_we  out  1 each  registered request/write strobe to slow memory.
REQ-013 mem_addr, mem_wdata  out  `WORD_LEN each  registered address/store data.
REQ-014 mem_rdata  in  `WORD_LEN  memory read data, valid only with mem_ack.
REQ-015 mem_ack  in  1  one-cycle completion pulse from memory.

Function
REQ-016 FSM states SHALL be IDLE, BUSY, DONE.
REQ-017 IDLE: if (MEM_R_EN|MEM_W_EN), SHALL register mem_req=1, mem_we=MEM_W_EN, mem_addr=ALU_res, mem_wdata=ST_value, clear wait counter, go BUSY.
REQ-018 BUSY: mem_req/mem_we/mem_addr/mem_wdata SHALL hold; counter increments each cycle without mem_ack.
REQ-019 BUSY with mem_ack: SHALL drop mem_req and mem_we next edge, latch mem_rdata into dataMem_out on reads (unchanged on writes), go DONE.
REQ-020 BUSY, counter reaching TIMEOUT without ack: SHALL drop mem_req, set err=1, load dataMem_out=0 on reads, go DONE.
REQ-021 DONE: SHALL unconditionally go IDLE next cycle; mem_req=0.
REQ-022 freeze SHALL equal (MEM_R_EN|MEM_W_EN) & (state!=DONE), except per REQ-031.
REQ-023 Minimum latency: request in IDLE at cycle 0, ack at cycle 1 -> DONE at cycle 2, freeze low at cycle 2, pipeline advances at edge ending cycle 2.
REQ-024 MEM_R_EN and MEM_W_EN both high: SHALL perform write only; dataMem_out unchanged.
REQ-025 mem_ack outside BUSY SHALL be ignored.
REQ-026 Back-to-back accesses SHALL each pass through DONE then IDLE; new request issues in IDLE cycle after DONE.
REQ-027 err SHALL remain set until rst.

Reset
REQ-028 On rst: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, dataMem_out=0, err=0, counter=0; rst overrides everything.
REQ-029 rst during BUSY SHALL abort access without completion; a request still asserted after rst deasserts SHALL be reissued from IDLE.

Configuration
REQ-030 Macro MEM_ACCESS_CTRL_RDBUF_EN SHALL compile in a one-entry read buffer (valid bit, address tag, data word).
REQ-031 With macro: read in IDLE with valid & tag==ALU_res & !MEM_W_EN SHALL drive freeze=0, dataMem_out=buffer data combinationally-selected, no mem_req, state stays IDLE.
REQ-032 With macro: ack-completed read SHALL fill buffer; write to tag address SHALL update buffer data; timed-out read SHALL not fill; rst SHALL clear valid.
REQ-033 Without macro: every access SHALL use the FSM path; behaviour identical to REQ-016..REQ-029.

Verification
REQ-034 Read 0x40, mem_ack at 3rd BUSY cycle with mem_rdata=0xDEADBEEF -> freeze high 4 cycles, dataMem_out=0xDEADBEEF in DONE, err=0.
REQ-035 Write 0x44 value 0x12345678, ack after 1 cycle -> mem_we=1, mem_wdata=0x12345678 for exactly one BUSY cycle then 0, dataMem_out unchanged.
REQ-036 Read with no ack, TIMEOUT=15 -> mem_req drops after 15 BUSY cycles, err=1, dataMem_out=0, freeze low in DONE.
REQ-037 rst pulsed during BUSY with MEM_R_EN held -> outputs at reset values, new mem_req issued first cycle after rst falls.
REQ-038 With MEM_ACCESS_CTRL_RDBUF_EN: read 0x80 (data 0x55), store 0x80=0x66, reread 0x80 -> second read freeze=0, dataMem_out=0x66, no mem_req.
